// File: rtl/core_pkg.sv
// Shared core types: load/store type encodings used by decode and the LSU,
// the LSU state machine states, and access-size helpers.
package core_pkg;

  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LT_LB   = 3'd1,
    LT_LH   = 3'd2,
    LT_LW   = 3'd3,
    LT_LBU  = 3'd4,
    LT_LHU  = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } store_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Bytes never misalign; halves need an even address, words a multiple of 4.
  function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] lsb);
    case (size)
      SZ_HALF: return lsb[0];
      SZ_WORD: return (lsb != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated write data for stores,
// lane selection and sign/zero extension for loads.
module lsu_align
  import core_pkg::*;
(
  input  acc_size_e   i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lsb)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = 32'h0;
    o_load_data = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_lsb;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be        = i_lsb[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one aligned access from decode, runs it through a
// req/gnt/rvalid memory handshake, and stalls the pipeline until done.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_read_i,
  input  logic              write_en_DMEM_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        store_type_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  lsu_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  acc_size_e         r_size;
  logic              r_unsigned;
  logic              r_is_load;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_load_data;

  logic       w_ld_ok, w_ld_uns, w_st_ok;
  acc_size_e  w_ld_size, w_st_size, w_size;
  logic       w_sel_load, w_sel_store, w_misalign, w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext_data;

  always_comb begin
    w_ld_ok   = 1'b1;
    w_ld_uns  = 1'b0;
    w_ld_size = SZ_WORD;
    case (load_type_e'(load_type_i))
      LT_LB:  w_ld_size = SZ_BYTE;
      LT_LH:  w_ld_size = SZ_HALF;
      LT_LW:  w_ld_size = SZ_WORD;
      LT_LBU: begin w_ld_size = SZ_BYTE; w_ld_uns = 1'b1; end
      LT_LHU: begin w_ld_size = SZ_HALF; w_ld_uns = 1'b1; end
      default: w_ld_ok = 1'b0;
    endcase

    w_st_ok   = 1'b1;
    w_st_size = SZ_WORD;
    case (store_type_e'(store_type_i))
      ST_SB:   w_st_size = SZ_BYTE;
      ST_SH:   w_st_size = SZ_HALF;
      ST_SW:   w_st_size = SZ_WORD;
      default: w_st_ok = 1'b0;
    endcase

    // A valid load wins over a simultaneous store.
    w_sel_load  = data_read_i && w_ld_ok;
    w_sel_store = !w_sel_load && write_en_DMEM_i && w_st_ok;
    w_size      = w_sel_load ? w_ld_size : w_st_size;
    w_misalign  = (w_sel_load || w_sel_store) && is_misaligned(w_size, addr_i[1:0]);
    w_accept    = (w_sel_load || w_sel_store) && !w_misalign;
  end

  lsu_align u_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_lsb        (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (mem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_ext_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= LSU_IDLE;
    else         r_state <= w_next;
  end

  // The IDLE-cycle outputs are combinational on the inputs, so they are also
  // gated by reset to keep every output quiet while reset is held.
  always_comb begin
    w_next       = r_state;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    load_valid_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = 4'b0000;
    case (r_state)
      LSU_IDLE: begin
        misalign_o = w_misalign && rst_ni;
        stall_o    = w_accept && rst_ni;
        if (w_accept) w_next = LSU_REQ;
      end
      LSU_REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = !r_is_load;
        mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_be_o    = w_be;
        mem_wdata_o = r_is_load ? '0 : w_wdata;
        if (mem_gnt_i) w_next = LSU_WAIT;
      end
      LSU_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) w_next = LSU_DONE;
      end
      LSU_DONE: begin
        load_valid_o = r_is_load;
        w_next       = LSU_IDLE;
      end
      default: w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_is_load    <= 1'b0;
      r_store_data <= '0;
      r_load_data  <= '0;
    end else begin
      if (r_state == LSU_IDLE && w_accept) begin
        r_addr       <= addr_i;
        r_size       <= w_size;
        r_unsigned   <= w_sel_load && w_ld_uns;
        r_is_load    <= w_sel_load;
        r_store_data <= store_data_i;
      end
      if (r_state == LSU_WAIT && mem_rvalid_i && r_is_load) r_load_data <= w_ext_data;
    end
  end

  assign load_data_o = r_load_data;

endmodule
